// File: rtl/acc_reducer.sv
// Serialises per-core accumulator contributions into N_ACC shared registers
// through one external pipelined adder, with a drain-then-load clear handshake.
module acc_reducer #(
  parameter int unsigned N_CORE = 5,
  parameter int unsigned N_ACC  = 2,
  parameter int unsigned TAG_W  = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_CORE-1:0][N_ACC-1:0]        acc_req_valid,
  input  logic [N_CORE-1:0][N_ACC-1:0][31:0]  acc_data,
  output logic [N_CORE-1:0][N_ACC-1:0]        acc_req_ready,
  output logic                                add_valid,
  output logic [31:0]                         add_a,
  output logic [31:0]                         add_b,
  output logic [TAG_W-1:0]                    add_tag,
  input  logic                                add_result_valid,
  input  logic [31:0]                         add_result,
  input  logic [TAG_W-1:0]                    add_result_tag,
  input  logic                                clear,
  input  logic [N_ACC-1:0][31:0]              clear_data,
  output logic                                clear_done,
  output logic [N_ACC-1:0][31:0]              acc_value,
  output logic                                idle
);

  localparam int unsigned N_FLAT = N_CORE * N_ACC;
  localparam int unsigned PTR_W  = (N_FLAT > 1) ? $clog2(N_FLAT) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [N_ACC-1:0]  busy_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [N_FLAT-1:0] elig;
  logic              grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              load;
  logic              res_hit;

  // Flat index core*N_ACC+acc matches the packed layout, so busy is replicated per core.
  assign elig = (!rst && state_q == RUN && !clear)
              ? (acc_req_valid & ~{N_CORE{busy_q}}) : '0;

  always_comb begin
    int unsigned f;
    logic [PTR_W-1:0] idx;
    grant     = 1'b0;
    grant_idx = '0;
    f         = 0;
    idx       = '0;
    for (int unsigned k = 1; k <= N_FLAT; k++) begin
      f = 32'(ptr_q) + k;
      if (f >= N_FLAT) f = f - N_FLAT;
      idx = PTR_W'(f);
      if (!grant && elig[idx]) begin
        grant     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    acc_req_ready = '0;
    add_valid     = grant;
    add_a         = '0;
    add_b         = '0;
    add_tag       = '0;
    for (int unsigned c = 0; c < N_CORE; c++) begin
      for (int unsigned a = 0; a < N_ACC; a++) begin
        if (grant && grant_idx == PTR_W'(c * N_ACC + a)) begin
          acc_req_ready[c][a] = 1'b1;
          add_a               = acc_value[a];
          add_b               = acc_data[c][a];
          add_tag             = TAG_W'(a);
        end
      end
    end
  end

  // Results for an accumulator that is not waiting (e.g. issued before reset) are dropped.
  always_comb begin
    res_hit = 1'b0;
    for (int unsigned a = 0; a < N_ACC; a++) begin
      if (add_result_tag == TAG_W'(a)) res_hit = busy_q[a];
    end
    res_hit = res_hit && add_result_valid && !rst;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      RUN: begin
        if (clear) begin
          if (busy_q == '0) load = 1'b1;
          else              state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!clear) begin
          state_d = RUN;
        end else if (busy_q == '0) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) load = 1'b0;
  end

  assign clear_done = load;
  assign idle       = (busy_q == '0) && (acc_req_valid == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      busy_q    <= '0;
      ptr_q     <= '0;
      acc_value <= '0;
    end else begin
      state_q <= state_d;
      if (grant) ptr_q <= grant_idx;
      for (int unsigned a = 0; a < N_ACC; a++) begin
        if (load) begin
          acc_value[a] <= clear_data[a];
        end else if (res_hit && add_result_tag == TAG_W'(a)) begin
          acc_value[a] <= add_result;
        end
        // A grant never targets the accumulator whose result returns this cycle.
        if (grant && add_tag == TAG_W'(a)) begin
          busy_q[a] <= 1'b1;
        end else if (res_hit && add_result_tag == TAG_W'(a)) begin
          busy_q[a] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_reducer.sv
// Directed bench for acc_reducer: a bench-side adder, request queues and a
// transaction-level model checked every cycle, plus literal per-test expectations.
module tb_acc_reducer;

  localparam int N_CORE = 5;
  localparam int N_ACC  = 2;
  localparam int TAG_W  = 1;
  localparam int NF     = N_CORE * N_ACC;

  logic                               clk = 1'b0;
  logic                               rst;
  logic [N_CORE-1:0][N_ACC-1:0]       acc_req_valid;
  logic [N_CORE-1:0][N_ACC-1:0][31:0] acc_data;
  logic [N_CORE-1:0][N_ACC-1:0]       acc_req_ready;
  logic                               add_valid;
  logic [31:0]                        add_a, add_b;
  logic [TAG_W-1:0]                   add_tag;
  logic                               add_result_valid;
  logic [31:0]                        add_result;
  logic [TAG_W-1:0]                   add_result_tag;
  logic                               clear;
  logic [N_ACC-1:0][31:0]             clear_data;
  logic                               clear_done;
  logic [N_ACC-1:0][31:0]             acc_value;
  logic                               idle;

  acc_reducer #(.N_CORE(N_CORE), .N_ACC(N_ACC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .acc_req_valid(acc_req_valid), .acc_data(acc_data), .acc_req_ready(acc_req_ready),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_tag(add_tag),
    .add_result_valid(add_result_valid), .add_result(add_result), .add_result_tag(add_result_tag),
    .clear(clear), .clear_data(clear_data), .clear_done(clear_done),
    .acc_value(acc_value), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      sum;
    int               due;
  } op_t;

  logic [31:0] m_acc  [N_ACC];
  logic [31:0] m_pend [N_ACC];
  bit          m_busy [N_ACC];
  int          m_ptr;
  bit          m_drain;

  logic [31:0] rq [NF][$];
  bit          pop_f [NF];
  op_t         aq [$];
  int          lat;
  int          cyc;
  int          dut_done;

  int          g_f [$];
  int          g_cyc [$];
  logic [31:0] g_a [$];
  logic [31:0] g_b [$];

  int n_checks;
  int n_pass;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                  name, got, got, exp, exp, cyc);
  endtask

  // Request driver and external adder: inputs change 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int c = 0; c < N_CORE; c++) begin
        for (int a = 0; a < N_ACC; a++) begin
          int f;
          f = c * N_ACC + a;
          if (pop_f[f]) begin
            if (rq[f].size() > 0) rq[f].delete(0);
            pop_f[f] = 1'b0;
          end
          acc_req_valid[c][a] = (rq[f].size() > 0);
          acc_data[c][a]      = (rq[f].size() > 0) ? rq[f][0] : 32'd0;
        end
      end
      add_result_valid = 1'b0;
      add_result       = '0;
      add_result_tag   = '0;
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        add_result_valid = 1'b1;
        add_result       = aq[0].sum;
        add_result_tag   = aq[0].tag;
        aq.delete(0);
      end
    end
  end

  // Per-cycle compare against the transaction model, then advance the model.
  always @(negedge clk) begin : compare
    logic [N_CORE-1:0][N_ACC-1:0] er;
    logic [NF-1:0] vflat;
    int  g, gc, ga, f;
    bit  allfree, done_e, idle_e;
    logic [31:0] adata;
    er     = '0;
    g      = -1;
    vflat  = acc_req_valid;
    allfree = 1'b1;
    for (int a = 0; a < N_ACC; a++) if (m_busy[a]) allfree = 1'b0;
    idle_e = allfree && (vflat == '0);
    if (!rst && !m_drain && !clear) begin
      for (int k = 1; k <= NF; k++) begin
        f = (m_ptr + k) % NF;
        if (g < 0 && vflat[f] && !m_busy[f % N_ACC]) g = f;
      end
    end
    done_e = !rst && clear && allfree;
    if (g >= 0) er[g / N_ACC][g % N_ACC] = 1'b1;

    chk("acc_req_ready", 32'(acc_req_ready), 32'(er));
    chk("add_valid", 32'(add_valid), 32'(g >= 0));
    chk("clear_done", 32'(clear_done), 32'(done_e));
    chk("idle", 32'(idle), 32'(idle_e));
    for (int a = 0; a < N_ACC; a++) chk("acc_value", acc_value[a], m_acc[a]);
    if (clear_done === 1'b1) dut_done++;

    if (g >= 0) begin
      gc    = g / N_ACC;
      ga    = g % N_ACC;
      adata = acc_data[gc][ga];
      chk("add_tag", 32'(add_tag), 32'(ga));
      chk("add_a", add_a, m_acc[ga]);
      chk("add_b", add_b, adata);
      g_f.push_back(g);
      g_cyc.push_back(cyc);
      g_a.push_back(add_a);
      g_b.push_back(add_b);
      aq.push_back('{tag: TAG_W'(ga), sum: add_a + add_b, due: cyc + lat});
      pop_f[g] = 1'b1;
    end

    if (rst) begin
      for (int a = 0; a < N_ACC; a++) begin
        m_acc[a]  = '0;
        m_busy[a] = 1'b0;
      end
      m_ptr   = 0;
      m_drain = 1'b0;
    end else begin
      if (add_result_valid && m_busy[add_result_tag]) begin
        m_acc[add_result_tag]  = m_acc[add_result_tag] + m_pend[add_result_tag];
        m_busy[add_result_tag] = 1'b0;
      end
      if (g >= 0) begin
        m_busy[ga] = 1'b1;
        m_pend[ga] = adata;
        m_ptr      = g;
      end
      if (done_e) for (int a = 0; a < N_ACC; a++) m_acc[a] = clear_data[a];
      m_drain = clear && !allfree;
    end
  end

  function automatic bit quiet();
    bit q;
    q = (aq.size() == 0);
    for (int f = 0; f < NF; f++) if (rq[f].size() > 0 || pop_f[f]) q = 1'b0;
    for (int a = 0; a < N_ACC; a++) if (m_busy[a]) q = 1'b0;
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_quiet(input string name, input int maxc);
    int n;
    n = 0;
    while (!quiet() && n < maxc) begin
      step();
      n++;
    end
    n_checks++;
    if (quiet()) n_pass++;
    else $display("FAIL %s_timeout: still busy after %0d cycles, required quiet", name, maxc);
  endtask

  task automatic wait_grants(input string name, input int cnt, input int maxc);
    int n;
    n = 0;
    while (g_f.size() < cnt && n < maxc) begin
      step();
      n++;
    end
    n_checks++;
    if (g_f.size() >= cnt) n_pass++;
    else $display("FAIL %s_grant_timeout: got %0d grants, required %0d", name, g_f.size(), cnt);
  endtask

  task automatic push(input int c, input int a, input logic [31:0] d);
    rq[c * N_ACC + a].push_back(d);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    g_f.delete();
    g_cyc.delete();
    g_a.delete();
    g_b.delete();
  endtask

  initial begin
    int t0, bad, cnt;
    int per_core [N_CORE];
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    dut_done = 0;
    lat      = 3;
    rst      = 1'b1;
    clear    = 1'b0;
    clear_data       = '0;
    acc_req_valid    = '0;
    acc_data         = '0;
    add_result_valid = 1'b0;
    add_result       = '0;
    add_result_tag   = '0;
    m_ptr   = 0;
    m_drain = 1'b0;
    for (int a = 0; a < N_ACC; a++) begin
      m_acc[a]  = '0;
      m_pend[a] = '0;
      m_busy[a] = 1'b0;
    end
    for (int f = 0; f < NF; f++) pop_f[f] = 1'b0;

    step();
    step();
    rst = 1'b0;
    chk("reset_acc0", acc_value[0], 32'd0);
    chk("reset_acc1", acc_value[1], 32'd0);
    chk("reset_ready", 32'(acc_req_ready), 32'd0);
    chk("reset_add_valid", 32'(add_valid), 32'd0);
    chk("reset_clear_done", 32'(clear_done), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);

    // T1: single contribution, latency 3
    do_reset();
    lat = 3;
    t0  = cyc + 1;
    push(2, 0, 32'd5);
    wait_quiet("t1", 40);
    chk("t1_grants", 32'(g_f.size()), 32'd1);
    if (g_f.size() >= 1) begin
      chk("t1_flat", 32'(g_f[0]), 32'd4);
      chk("t1_grant_cycle", 32'(g_cyc[0]), 32'(t0));
      chk("t1_add_a", g_a[0], 32'd0);
      chk("t1_add_b", g_b[0], 32'd5);
    end
    chk("t1_acc0", acc_value[0], 32'd5);
    chk("t1_idle", 32'(idle), 32'd1);

    // T2: three cores contend for acc1, latency 4
    do_reset();
    lat = 4;
    push(0, 1, 32'd1);
    push(1, 1, 32'd2);
    push(2, 1, 32'd3);
    wait_quiet("t2", 60);
    chk("t2_grants", 32'(g_f.size()), 32'd3);
    if (g_f.size() >= 3) begin
      chk("t2_order0", 32'(g_f[0]), 32'd1);
      chk("t2_order1", 32'(g_f[1]), 32'd3);
      chk("t2_order2", 32'(g_f[2]), 32'd5);
      chk("t2_gap01_ge5", 32'(g_cyc[1] - g_cyc[0] >= 5), 32'd1);
      chk("t2_gap12_ge5", 32'(g_cyc[2] - g_cyc[1] >= 5), 32'd1);
    end
    chk("t2_acc1", acc_value[1], 32'd6);

    // T3: independent accumulators proceed in parallel
    do_reset();
    lat = 3;
    push(0, 0, 32'd7);
    push(1, 1, 32'd9);
    wait_quiet("t3", 40);
    chk("t3_grants", 32'(g_f.size()), 32'd2);
    if (g_f.size() >= 2) begin
      chk("t3_first", 32'(g_f[0]), 32'd3);
      chk("t3_second", 32'(g_f[1]), 32'd0);
      chk("t3_back_to_back", 32'(g_cyc[1] - g_cyc[0]), 32'd1);
    end
    chk("t3_acc0", acc_value[0], 32'd7);
    chk("t3_acc1", acc_value[1], 32'd9);

    // T4: five cores on acc0, latency 1, 20 grants
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < N_CORE; c++) push(c, 0, 32'(c + 1));
    wait_quiet("t4", 200);
    chk("t4_grants", 32'(g_f.size()), 32'd20);
    for (int c = 0; c < N_CORE; c++) per_core[c] = 0;
    bad = 0;
    cnt = g_f.size();
    for (int i = 0; i < cnt; i++) begin
      per_core[g_f[i] / N_ACC]++;
      if (g_f[i] != 2 * ((i + 1) % N_CORE)) bad++;
    end
    for (int c = 0; c < N_CORE; c++) chk($sformatf("t4_core%0d_count", c), 32'(per_core[c]), 32'd4);
    chk("t4_rr_order_errors", 32'(bad), 32'd0);
    chk("t4_acc0", acc_value[0], 32'd60);

    // T5: clear while an add on acc0 is in flight
    do_reset();
    lat = 5;
    dut_done = 0;
    push(0, 0, 32'd11);
    wait_grants("t5", 1, 20);
    clear         = 1'b1;
    clear_data[0] = 32'd100;
    clear_data[1] = 32'd200;
    push(1, 1, 32'd50);
    t0 = 0;
    while (dut_done == 0 && t0 < 30) begin
      step();
      t0++;
    end
    clear = 1'b0;
    chk("t5_done_seen", 32'(dut_done), 32'd1);
    chk("t5_no_grant_during_clear", 32'(g_f.size()), 32'd1);
    chk("t5_load_acc0", acc_value[0], 32'd100);
    chk("t5_load_acc1", acc_value[1], 32'd200);
    wait_quiet("t5", 40);
    chk("t5_done_pulses", 32'(dut_done), 32'd1);
    chk("t5_acc1_after", acc_value[1], 32'd250);
    chk("t5_acc0_after", acc_value[0], 32'd100);

    // T6: reset while acc1 is busy; the late result must be dropped
    do_reset();
    lat = 8;
    push(3, 1, 32'd42);
    wait_grants("t6", 1, 20);
    step();
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_add_valid", 32'(add_valid), 32'd0);
    chk("t6_rst_ready", 32'(acc_req_ready), 32'd0);
    rst = 1'b0;
    wait_quiet("t6", 30);
    step();
    chk("t6_acc1", acc_value[1], 32'd0);
    chk("t6_acc0", acc_value[0], 32'd0);
    chk("t6_ready", 32'(acc_req_ready), 32'd0);
    chk("t6_add_valid", 32'(add_valid), 32'd0);
    chk("t6_clear_done", 32'(clear_done), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
